// File: rtl/raiz_pkg.sv
// Shared types and constants for the restoring square-root controller.
package raiz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        LOAD,
        CMP,
        FIN
    } raiz_state_t;

    // Counter width for a given iteration count; never narrower than 1 bit.
    function automatic int cnt_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    localparam int RAIZ_WIDTH = 32;
    localparam int RAIZ_ITER  = RAIZ_WIDTH / 2;
    localparam int RAIZ_CNT_W = cnt_w(RAIZ_ITER);

endpackage

// File: rtl/raiz_ctrl_if.sv
// Control/status bundle between the square-root controller and its datapath.
// master: the side that raises init and returns z; slave: the controller.
interface raiz_ctrl_if;
    logic init;
    logic z;
    logic rst_dp;
    logic s_shift;
    logic s_load;
    logic s_bit;
    logic s_sub;
    logic busy;
    logic done;

    modport master (
        output init, z,
        input  rst_dp, s_shift, s_load, s_bit, s_sub, busy, done
    );

    modport slave (
        input  init, z,
        output rst_dp, s_shift, s_load, s_bit, s_sub, busy, done
    );
endinterface

// File: rtl/raiz_cnt.sv
// Loadable down-counter for the root-digit iterations; k flags zero.
module raiz_cnt #(
    parameter int          W    = 4,
    parameter int unsigned INIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic k
);
    logic [W-1:0] cnt_q, cnt_d;

    // Load takes priority; decrement stops at zero so the count cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = W'(INIT);
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign k = (cnt_q == '0);
endmodule

// File: rtl/raiz_ctrl.sv
// Sequencer for the restoring square-root datapath: CLEAR, then ITER rounds
// of SHIFT/LOAD/CMP, then FIN. done is level-held until the next accepted
// init; define RAIZ_DONE_PULSE_EN to make done a one-cycle pulse instead.
module raiz_ctrl
    import raiz_pkg::*;
#(
    parameter int WIDTH = RAIZ_WIDTH,
    parameter int ITER  = WIDTH / 2
) (
    input  logic        clk,
    input  logic        rst,
    raiz_ctrl_if.slave  bus
);
    localparam int CNT_W = cnt_w(ITER);

    raiz_state_t state_q;
    logic        rst_dp_q, shift_q, load_q, cmp_q, busy_q, done_q;
    logic        cnt_load, cnt_dec, k;

    // A run is armed only from IDLE; the count steps once per non-final CMP.
    assign cnt_load = (state_q == IDLE) && bus.init;
    assign cnt_dec  = (state_q == CMP) && !k;

    raiz_cnt #(
        .W    (CNT_W),
        .INIT (ITER - 1)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .k    (k)
    );

    // State and registered strobes; each strobe is set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rst_dp_q <= 1'b0;
            shift_q  <= 1'b0;
            load_q   <= 1'b0;
            cmp_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rst_dp_q <= 1'b0;
            shift_q  <= 1'b0;
            load_q   <= 1'b0;
            cmp_q    <= 1'b0;
            busy_q   <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef RAIZ_DONE_PULSE_EN
                    done_q <= 1'b0;
`endif
                    if (bus.init) begin
                        state_q  <= CLEAR;
                        rst_dp_q <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                CLEAR: begin
                    state_q <= SHIFT;
                    shift_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    state_q <= LOAD;
                    load_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    state_q <= CMP;
                    cmp_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
                CMP: begin
                    if (k) begin
                        state_q <= FIN;
                    end else begin
                        state_q <= SHIFT;
                        shift_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rst_dp  = rst_dp_q;
    assign bus.s_shift = shift_q;
    assign bus.s_load  = load_q;
    // Root bit and subtract follow the comparator only while comparing.
    assign bus.s_bit   = cmp_q & bus.z;
    assign bus.s_sub   = cmp_q & bus.z;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_raiz_ctrl.sv
// Bench for raiz_ctrl: arithmetic datapath model closes the z loop, a
// cycle-phase model predicts every strobe, plus literal result checks.
module tb_raiz_ctrl;
    import raiz_pkg::*;

    localparam int W    = 32;
    localparam int IT   = 16;
    localparam int FINP = 3 * IT + 2;   // phase of FIN counted from init edge

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_r = 1'b1;
    logic [31:0] radicand = 32'd0;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    raiz_ctrl_if bus();
    assign bus.init = init_r;

    // Restoring square-root datapath model driven by the DUT strobes.
    longint unsigned rem_m = 0, aux_m = 0, root_m = 0, rad_m = 0;
    assign bus.z = (aux_m <= rem_m);

    raiz_ctrl #(.WIDTH(W), .ITER(IT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.rst_dp) begin
            rem_m  <= 0;
            root_m <= 0;
            aux_m  <= 0;
            rad_m  <= longint'(radicand);
        end else begin
            if (bus.s_shift) begin
                rem_m  <= (rem_m << 2) | ((rad_m >> 30) & 64'd3);
                rad_m  <= (rad_m << 2) & 64'hFFFF_FFFF;
                root_m <= root_m << 1;
            end
            // root was just doubled (LSB 0), so {root,1} = 4*previous_root + 1
            if (bus.s_load) aux_m <= (root_m << 1) | 64'd1;
            if (bus.s_sub)  rem_m <= rem_m - aux_m;
            if (bus.s_bit)  root_m <= root_m | 64'd1;
        end
    end

    // Expected-output model: ph = cycles since the accepted init (0 = idle).
    int ph = 0;
    bit done_e = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph     <= 0;
            done_e <= 1'b0;
            chk_en <= 1'b1;
        end else if (ph == 0) begin
`ifdef RAIZ_DONE_PULSE_EN
            done_e <= 1'b0;
`endif
            if (init_r) begin
                ph     <= 1;
                done_e <= 1'b0;
            end
        end else if (ph == FINP) begin
            ph     <= 0;
            done_e <= 1'b1;
        end else begin
            ph <= ph + 1;
        end
    end

    // Per-cycle compare of all outputs against the phase model.
    always @(negedge clk) begin
        bit       inrun, ecmp;
        int       sl;
        logic [6:0] expv, actv;
        if (chk_en) begin
            inrun = (ph >= 2) && (ph <= FINP - 1);
            sl    = inrun ? (ph - 2) % 3 : 3;
            ecmp  = (sl == 2);
            expv  = {ph == 1, sl == 0, sl == 1, ecmp && bus.z, ecmp && bus.z,
                     (ph >= 1) && (ph <= FINP - 1), done_e};
            actv  = {bus.rst_dp, bus.s_shift, bus.s_load, bus.s_bit, bus.s_sub,
                     bus.busy, bus.done};
            nvec++;
            if (actv !== expv) begin
                nfail++;
                $display("FAIL outputs t=%0t ph=%0d act=%b exp=%b (rst_dp,shift,load,bit,sub,busy,done)",
                         $time, ph, actv, expv);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    int done_n, n_sh, n_ld, n_bit, n_sub, n_clr;

    // Start a run and follow it until done, a timeout, or an injected reset.
    task automatic run(input logic [31:0] rv, input bit pokes, input int abort_at);
        int n;
        @(posedge clk); #1;
        radicand = rv;
        init_r   = 1'b1;
        @(posedge clk); #1;
        init_r = 1'b0;
        n = 0; done_n = 0; n_sh = 0; n_ld = 0; n_bit = 0; n_sub = 0; n_clr = 0;
        while (done_n == 0 && n < 120) begin
            @(negedge clk);
            n++;
            n_sh  += int'(bus.s_shift);
            n_ld  += int'(bus.s_load);
            n_bit += int'(bus.s_bit);
            n_sub += int'(bus.s_sub);
            n_clr += int'(bus.rst_dp);
            if (bus.done) done_n = n;
            if (pokes) init_r = (n == 5 || n == 30);
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("abort_busy", longint'(bus.busy), 0);
                chk("abort_done", longint'(bus.done), 0);
                chk("abort_strobes", longint'({bus.rst_dp, bus.s_shift, bus.s_load, bus.s_sub}), 0);
                return;
            end
        end
        init_r = 1'b0;
        chk("done_latency", done_n, 51);
    endtask

    initial begin
        int n, c1, c2, dcnt;

        // Reset held with init high: everything stays quiet.
        repeat (2) begin
            @(negedge clk);
            chk("reset_outs", longint'({bus.rst_dp, bus.s_shift, bus.s_load, bus.s_bit,
                                        bus.s_sub, bus.busy, bus.done}), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("clear_after_reset", longint'({bus.rst_dp, bus.busy}), 3);
        init_r = 1'b0;
        n = 0;
        while (!bus.done && n < 120) begin @(negedge clk); n++; end
        chk("first_run_done", longint'(bus.done), 1);

        // Radicand 144.
        run(32'd144, 1'b0, 0);
        chk("root_144", longint'(root_m), 12);
        chk("rem_144", longint'(rem_m), 0);
        chk("shifts_144", n_sh, 16);
        chk("loads_144", n_ld, 16);
        chk("bits_144", n_bit, 2);

        // All-ones radicand: subtract on every compare.
        run(32'hFFFF_FFFF, 1'b0, 0);
        chk("root_max", longint'(root_m), 65535);
        chk("rem_max", longint'(rem_m), 131070);
        chk("subs_max", n_sub, 16);

        // Abort at cycle 20, then a clean run with 50.
        run(32'd1000, 1'b0, 20);
        run(32'd50, 1'b0, 0);
        chk("root_50", longint'(root_m), 7);
        chk("rem_50", longint'(rem_m), 1);

        // init pokes during a run are ignored.
        run(32'd1000, 1'b1, 0);
        chk("clears_poked", n_clr, 1);
        chk("root_1000", longint'(root_m), 31);
        chk("rem_1000", longint'(rem_m), 39);

        // done hold behaviour with init low after the run.
        dcnt = 0;
        repeat (9) begin @(negedge clk); dcnt += int'(bus.done); end
`ifdef RAIZ_DONE_PULSE_EN
        chk("done_after", dcnt, 0);
`else
        chk("done_after", dcnt, 9);
`endif

        // init held high: second CLEAR lands at cycle 52, done high one cycle.
        @(posedge clk); #1;
        init_r = 1'b1;
        @(posedge clk); #1;
        n = 0; c1 = 0; c2 = 0; dcnt = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (bus.rst_dp) begin
                if (c1 == 0) c1 = n;
                else if (c2 == 0) c2 = n;
            end
            if (n <= 52) dcnt += int'(bus.done);
        end
        init_r = 1'b0;
        chk("held_clear1", c1, 1);
        chk("held_clear2", c2, 52);
        chk("held_done_cycles", dcnt, 1);
        n = 0;
        while (!bus.done && n < 120) begin @(negedge clk); n++; end
        chk("held_drain_done", longint'(bus.done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
